ddr4_axi_cmd_issue_fsm: RTL and testbench

Command-issue controller that drives the AXI-to-MC command translator. It paces its "next" input and completes the AXI address handshake. One instance serves each of the read and write address channels. The block waits until the translator reports no further pending MC bursts, then returns axready. It gates MC command issue on MC readiness, on a credit pool for outstanding commands and, for the write instance, on write-data availability.

---
 rtl/ddr4_axi_cmd_issue_fsm_if.sv | 25 ++
 rtl/ddr4_axi_cmd_issue_fsm.sv | 119 +++++++++++
 tb/tb_ddr4_axi_cmd_issue_fsm.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_axi_cmd_issue_fsm_if.sv
// Handshake bundle between the AXI address channel, the command translator
// and the memory controller for one command-issue FSM instance.
interface ddr4_axi_cmd_issue_fsm_if;
  // axvalid/axready: the requester holds axvalid high with a stable payload until the one-cycle axready pulse.
  // cmd_en/app_rdy: a command transfers on any cycle where both are high, and next pulses in that same cycle.
  logic       axvalid;
  logic       axready;
  logic       next_pending;
  logic       next;
  logic       cmd_en;
  logic [2:0] cmd_instr;
  logic       app_rdy;
  logic       w_data_rdy;

  // The master side is the issue FSM.
  modport master (
    input  axvalid, next_pending, app_rdy, w_data_rdy,
    output axready, next, cmd_en, cmd_instr
  );

  modport slave (
    output axvalid, next_pending, app_rdy, w_data_rdy,
    input  axready, next, cmd_en, cmd_instr
  );
endinterface

// File: rtl/ddr4_axi_cmd_issue_fsm.sv
// AXI address-channel command-issue FSM with an outstanding-command credit pool.
// Optional watchdog enabled by defining DDR4_AXI_CMD_TIMEOUT_EN.
module ddr4_axi_cmd_issue_fsm #(
  parameter int C_MC_RD_INST     = 0,
  parameter int C_CREDITS        = 16,
  parameter int C_CREDIT_W       = 7,
  parameter int C_TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ddr4_axi_cmd_issue_fsm_if.master bus,
  input  logic                  credit_return,
  output logic [C_CREDIT_W-1:0] credits_avail,
  output logic                  credit_err,
  output logic                  timeout,
  output logic [1:0]            state_dbg
);

  if (C_CREDITS < 1 || C_CREDITS > 64 || (2 ** C_CREDIT_W) <= C_CREDITS) begin : g_bad_credit_cfg
    $error("ddr4_axi_cmd_issue_fsm: invalid C_CREDITS/C_CREDIT_W combination");
  end
  if (C_TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("ddr4_axi_cmd_issue_fsm: C_TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [C_CREDIT_W-1:0] CREDITS_FULL = C_CREDIT_W'(C_CREDITS);
  localparam logic [2:0]            INSTR        = (C_MC_RD_INST != 0) ? 3'b001 : 3'b000;

  state_t                state_q, state_d;
  logic [C_CREDIT_W-1:0] credits_q;
  logic                  credit_err_q;
  logic                  cmd_en_d;
  logic                  axready_d;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_en_d  = 1'b0;
    axready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.axvalid) state_d = ISSUE;
      end
      ISSUE: begin
        // Read instances never wait on write data.
        cmd_en_d = (credits_q != '0) && ((C_MC_RD_INST != 0) || bus.w_data_rdy);
        if (cmd_en_d && bus.app_rdy && !bus.next_pending) state_d = DONE;
      end
      DONE: begin
        axready_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = cmd_en_d & bus.app_rdy;

  // A simultaneous accept and return cancel out, so the full-pool check
  // only matters when no command is taking a credit this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credits_q    <= CREDITS_FULL;
      credit_err_q <= 1'b0;
    end else if (accept && !credit_return) begin
      credits_q <= credits_q - 1'b1;
    end else if (!accept && credit_return) begin
      if (credits_q == CREDITS_FULL) credit_err_q <= 1'b1;
      else                           credits_q    <= credits_q + 1'b1;
    end
  end

`ifdef DDR4_AXI_CMD_TIMEOUT_EN
  localparam int               TO_W   = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(C_TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;
  logic            stall;

  assign stall = cmd_en_d & ~bus.app_rdy;

  // The flag rises on the edge that completes the C_TIMEOUT_CYCLES-th stalled cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != ISSUE || accept)      to_cnt_q <= '0;
      else if (stall && to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + 1'b1;
      if (stall && to_cnt_q >= TO_MAX - 1'b1) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign bus.cmd_en    = cmd_en_d;
  assign bus.next      = accept;
  assign bus.axready   = axready_d;
  assign bus.cmd_instr = INSTR;
  assign credits_avail = credits_q;
  assign credit_err    = credit_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ddr4_axi_cmd_issue_fsm.sv
// Directed bench for ddr4_axi_cmd_issue_fsm: read, write and small-pool instances
// driven with hand-computed expectations.
module tb_ddr4_axi_cmd_issue_fsm;

  localparam int W = 7;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

`ifdef DDR4_AXI_CMD_TIMEOUT_EN
  localparam logic EXP_TIMEOUT = 1'b1;
`else
  localparam logic EXP_TIMEOUT = 1'b0;
`endif

  logic clk;
  logic reset_n;

  ddr4_axi_cmd_issue_fsm_if rd_if ();
  ddr4_axi_cmd_issue_fsm_if wr_if ();
  ddr4_axi_cmd_issue_fsm_if cr_if ();

  logic         rd_ret, wr_ret, cr_ret;
  logic [W-1:0] rd_cred, wr_cred, cr_cred;
  logic         rd_err, wr_err, cr_err;
  logic         rd_to, wr_to, cr_to;
  logic [1:0]   rd_st, wr_st, cr_st;

  ddr4_axi_cmd_issue_fsm #(.C_MC_RD_INST(1), .C_CREDITS(16), .C_CREDIT_W(W), .C_TIMEOUT_CYCLES(8)) u_rd (
    .clk(clk), .reset_n(reset_n), .bus(rd_if.master), .credit_return(rd_ret),
    .credits_avail(rd_cred), .credit_err(rd_err), .timeout(rd_to), .state_dbg(rd_st)
  );

  ddr4_axi_cmd_issue_fsm #(.C_MC_RD_INST(0), .C_CREDITS(16), .C_CREDIT_W(W), .C_TIMEOUT_CYCLES(8)) u_wr (
    .clk(clk), .reset_n(reset_n), .bus(wr_if.master), .credit_return(wr_ret),
    .credits_avail(wr_cred), .credit_err(wr_err), .timeout(wr_to), .state_dbg(wr_st)
  );

  ddr4_axi_cmd_issue_fsm #(.C_MC_RD_INST(1), .C_CREDITS(2), .C_CREDIT_W(W), .C_TIMEOUT_CYCLES(8)) u_cr (
    .clk(clk), .reset_n(reset_n), .bus(cr_if.master), .credit_return(cr_ret),
    .credits_avail(cr_cred), .credit_err(cr_err), .timeout(cr_to), .state_dbg(cr_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive point: 1 time unit after the active edge.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_if.axvalid = 0; rd_if.next_pending = 0; rd_if.app_rdy = 0; rd_if.w_data_rdy = 0;
    wr_if.axvalid = 0; wr_if.next_pending = 0; wr_if.app_rdy = 0; wr_if.w_data_rdy = 0;
    cr_if.axvalid = 0; cr_if.next_pending = 0; cr_if.app_rdy = 0; cr_if.w_data_rdy = 0;
    rd_ret = 0; wr_ret = 0; cr_ret = 0;
  endtask

  logic app_seq [7];
  logic np_seq  [7];
  int   n_next, n_axr;

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    reset_n = 0;
    repeat (2) after_edge();
    reset_n = 1;

    // reset state
    @(negedge clk);
    check("rst_state",   32'(rd_st), 32'(S_IDLE));
    check("rst_axready", 32'(rd_if.axready), 0);
    check("rst_cmd_en",  32'(rd_if.cmd_en), 0);
    check("rst_next",    32'(rd_if.next), 0);
    check("rst_credits", 32'(rd_cred), 16);
    check("rst_cr_cred", 32'(cr_cred), 2);
    check("rst_err",     32'(rd_err), 0);
    check("rst_timeout", 32'(rd_to), 0);

    // single burst on the read instance
    after_edge();
    rd_if.axvalid = 1; rd_if.next_pending = 0; rd_if.app_rdy = 1;
    @(negedge clk);
    check("sb_idle_cmd_en", 32'(rd_if.cmd_en), 0);
    after_edge();
    @(negedge clk);
    check("sb_state_issue", 32'(rd_st), 32'(S_ISSUE));
    check("sb_cmd_en",      32'(rd_if.cmd_en), 1);
    check("sb_next",        32'(rd_if.next), 1);
    check("sb_instr",       32'(rd_if.cmd_instr), 32'h1);
    check("sb_axready_lo",  32'(rd_if.axready), 0);
    after_edge();
    @(negedge clk);
    check("sb_axready",  32'(rd_if.axready), 1);
    check("sb_done_en",  32'(rd_if.cmd_en), 0);
    check("sb_credits",  32'(rd_cred), 15);
    after_edge();
    rd_if.axvalid = 0;
    @(negedge clk);
    check("sb_axready_pulse", 32'(rd_if.axready), 0);
    check("sb_back_idle",     32'(rd_st), 32'(S_IDLE));

    // four-burst INCR with app_rdy toggling 1,0,1,1,0,1
    app_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    np_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    n_next = 0;
    n_axr  = 0;
    after_edge();
    rd_if.axvalid = 1;
    for (int i = 0; i < 7; i++) begin
      rd_if.app_rdy      = app_seq[i];
      rd_if.next_pending = np_seq[i];
      @(negedge clk);
      n_next += int'(rd_if.next);
      n_axr  += int'(rd_if.axready);
      after_edge();
    end
    rd_if.app_rdy = 0;
    @(negedge clk);
    n_axr += int'(rd_if.axready);
    check("incr_axready_done", 32'(rd_if.axready), 1);
    check("incr_next_count",   32'(n_next), 4);
    check("incr_axready_count", 32'(n_axr), 1);
    check("incr_credits",      32'(rd_cred), 11);
    after_edge();
    rd_if.axvalid = 0;

    // credit exhaustion on the two-credit instance
    cr_if.axvalid = 1; cr_if.next_pending = 0; cr_if.app_rdy = 1;
    n_next = 0;
    n_axr  = 0;
    repeat (6) begin
      @(negedge clk);
      n_next += int'(cr_if.next);
      n_axr  += int'(cr_if.axready);
      after_edge();
    end
    @(negedge clk);
    check("cr_two_next",    32'(n_next), 2);
    check("cr_two_axready", 32'(n_axr), 2);
    check("cr_empty",       32'(cr_cred), 0);
    check("cr_idle_gap",    32'(cr_st), 32'(S_IDLE));
    after_edge();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cr_stall_state", 32'(cr_st), 32'(S_ISSUE));
      check("cr_stall_cmd_en", 32'(cr_if.cmd_en), 0);
      after_edge();
    end
    cr_ret = 1;
    @(negedge clk);
    check("cr_ret_cycle_en", 32'(cr_if.cmd_en), 0);
    after_edge();
    cr_ret = 0;
    @(negedge clk);
    check("cr_one_credit", 32'(cr_cred), 1);
    check("cr_resume_en",  32'(cr_if.cmd_en), 1);
    check("cr_resume_next", 32'(cr_if.next), 1);
    after_edge();
    @(negedge clk);
    check("cr_third_axready", 32'(cr_if.axready), 1);
    check("cr_third_credits", 32'(cr_cred), 0);
    after_edge();
    cr_if.axvalid = 0;

    // write gating: w_data_rdy low for 5 ISSUE cycles
    wr_if.axvalid = 1; wr_if.next_pending = 0; wr_if.app_rdy = 1; wr_if.w_data_rdy = 0;
    @(negedge clk);
    check("wr_idle", 32'(wr_st), 32'(S_IDLE));
    after_edge();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wr_gated_en",    32'(wr_if.cmd_en), 0);
      check("wr_gated_state", 32'(wr_st), 32'(S_ISSUE));
      after_edge();
    end
    wr_if.w_data_rdy = 1;
    @(negedge clk);
    check("wr_cmd_en", 32'(wr_if.cmd_en), 1);
    check("wr_instr",  32'(wr_if.cmd_instr), 32'h0);
    check("wr_next",   32'(wr_if.next), 1);
    after_edge();
    wr_if.w_data_rdy = 0;
    @(negedge clk);
    check("wr_axready", 32'(wr_if.axready), 1);
    check("wr_credits", 32'(wr_cred), 15);
    after_edge();
    wr_if.axvalid = 0;

    // drain read pool to 5, then accept and return in the same cycle
    rd_if.axvalid = 1; rd_if.next_pending = 1; rd_if.app_rdy = 1;
    @(negedge clk);
    after_edge();
    repeat (6) begin
      @(negedge clk);
      after_edge();
    end
    rd_if.next_pending = 0;
    rd_ret = 1;
    @(negedge clk);
    check("sim_pre_credits", 32'(rd_cred), 5);
    check("sim_accept",      32'(rd_if.next), 1);
    after_edge();
    rd_ret = 0;
    @(negedge clk);
    check("sim_credits_hold", 32'(rd_cred), 5);
    check("sim_axready",      32'(rd_if.axready), 1);
    after_edge();
    rd_if.axvalid = 0;
    rd_if.app_rdy = 0;

    // refill to full, then one extra return
    rd_ret = 1;
    repeat (11) after_edge();
    rd_ret = 0;
    @(negedge clk);
    check("refill_credits", 32'(rd_cred), 16);
    check("refill_no_err",  32'(rd_err), 0);
    after_edge();
    rd_ret = 1;
    after_edge();
    rd_ret = 0;
    @(negedge clk);
    check("over_err",     32'(rd_err), 1);
    check("over_credits", 32'(rd_cred), 16);
    repeat (3) after_edge();
    @(negedge clk);
    check("err_sticky", 32'(rd_err), 1);

    // watchdog: app_rdy held low with cmd_en high
    after_edge();
    rd_if.axvalid = 1; rd_if.next_pending = 0; rd_if.app_rdy = 0;
    after_edge();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_before_limit", 32'(rd_to), 0);
      after_edge();
    end
    @(negedge clk);
    check("to_after_limit", 32'(rd_to), 32'(EXP_TIMEOUT));
    check("to_stall_en",    32'(rd_if.cmd_en), 1);

    // reset in the middle of ISSUE
    after_edge();
    reset_n = 0;
    after_edge();
    @(negedge clk);
    check("mid_rst_state",   32'(rd_st), 32'(S_IDLE));
    check("mid_rst_cmd_en",  32'(rd_if.cmd_en), 0);
    check("mid_rst_next",    32'(rd_if.next), 0);
    check("mid_rst_axready", 32'(rd_if.axready), 0);
    check("mid_rst_credits", 32'(rd_cred), 16);
    check("mid_rst_err",     32'(rd_err), 0);
    check("mid_rst_timeout", 32'(rd_to), 0);
    check("mid_rst_cr_cred", 32'(cr_cred), 2);
    check("mid_rst_wr_cred", 32'(wr_cred), 16);
    after_edge();
    reset_n = 1;
    idle_inputs();
    repeat (2) after_edge();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so a stuck run still reports.
  initial begin
    #100000;
    $display("FAIL watchdog_time_limit got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
